// File: rtl/inst_fifo_if.sv
// Fetch/decode handshake bundle for the dual-ported instruction buffer.
// master = fetch/decode side, slave = the FIFO itself.
interface inst_fifo_if;
   logic        flush;
   logic        write_en1;
   logic        write_en2;
   logic [31:0] write_inst1;
   logic [31:0] write_inst2;
   logic [31:0] write_addr1;
   logic [31:0] write_addr2;
   logic        read_en1;
   logic        read_en2;
   logic [31:0] read_inst1;
   logic [31:0] read_inst2;
   logic [31:0] read_addr1;
   logic [31:0] read_addr2;
   logic        read_valid1;
   logic        read_valid2;
   logic        empty;
   logic        fifo_full;

   modport master (
      output flush, write_en1, write_en2,
      output write_inst1, write_inst2,
      output write_addr1, write_addr2,
      output read_en1, read_en2,
      input  read_inst1, read_inst2,
      input  read_addr1, read_addr2,
      input  read_valid1, read_valid2,
      input  empty, fifo_full
   );

   modport slave (
      input  flush, write_en1, write_en2,
      input  write_inst1, write_inst2,
      input  write_addr1, write_addr2,
      input  read_en1, read_en2,
      output read_inst1, read_inst2,
      output read_addr1, read_addr2,
      output read_valid1, read_valid2,
      output empty, fifo_full
   );
endinterface

// File: rtl/inst_fifo.sv
// Dual-write/dual-read show-ahead instruction buffer between fetch and decode.
// Optional macro INST_FIFO_PERF_EN adds full/empty cycle counters.
module inst_fifo #(
   parameter int DEPTH = 16
) (
   input logic        clk,
   input logic        rst,
   inst_fifo_if.slave bus
`ifdef INST_FIFO_PERF_EN
   ,
   output logic [31:0] perf_full_cycles,
   output logic [31:0] perf_empty_cycles
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   addr_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr1;
   logic [AW-1:0] rd_ptr1;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic [1:0]    nw;
   logic [1:0]    nr;
   logic          valid1;
   logic          valid2;
   logic          full;

   assign wr_ptr1 = wr_ptr + AW'(1);
   assign rd_ptr1 = rd_ptr + AW'(1);
   assign valid1  = (count != '0);
   assign valid2  = (count >= (AW+1)'(2));
   assign full    = (count >= (AW+1)'(DEPTH - 1));

   // Accepted write/read counts; full is judged on the registered count
   always_comb begin
      nw = 2'd0;
      nr = 2'd0;
      if (!full && bus.write_en1)
         nw = bus.write_en2 ? 2'd2 : 2'd1;
      if (bus.read_en1 && valid1)
         nr = (bus.read_en2 && valid2) ? 2'd2 : 2'd1;
      count_nxt = count + (AW+1)'(nw) - (AW+1)'(nr);
   end

   // Pointer and occupancy state; flush empties the buffer in one edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(nw);
         rd_ptr <= rd_ptr + AW'(nr);
         count  <= count_nxt;
      end
   end

   // Entry storage; slot 2 lands one past slot 1, wrapping naturally
   always_ff @(posedge clk) begin
      if (!bus.flush && nw != 2'd0) begin
         inst_mem[wr_ptr] <= bus.write_inst1;
         addr_mem[wr_ptr] <= bus.write_addr1;
      end
      if (!bus.flush && nw == 2'd2) begin
         inst_mem[wr_ptr1] <= bus.write_inst2;
         addr_mem[wr_ptr1] <= bus.write_addr2;
      end
   end

   assign bus.read_valid1 = valid1;
   assign bus.read_valid2 = valid2;
   assign bus.read_inst1  = valid1 ? inst_mem[rd_ptr]  : '0;
   assign bus.read_addr1  = valid1 ? addr_mem[rd_ptr]  : '0;
   assign bus.read_inst2  = valid2 ? inst_mem[rd_ptr1] : '0;
   assign bus.read_addr2  = valid2 ? addr_mem[rd_ptr1] : '0;
   assign bus.empty       = !valid1;
   assign bus.fifo_full   = full;

`ifdef INST_FIFO_PERF_EN
   // Saturating stall counters; survive flush, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_full_cycles  <= '0;
         perf_empty_cycles <= '0;
      end else begin
         if (full && perf_full_cycles != '1)
            perf_full_cycles <= perf_full_cycles + 32'd1;
         if (!valid1 && perf_empty_cycles != '1)
            perf_empty_cycles <= perf_empty_cycles + 32'd1;
      end
   end
`endif

endmodule
